sound_rom_arbiter: RTL and testbench

SOUND_ROM_ARBITER -- requirements
Module: sound_rom_arbiter

---
 rtl/sound_pkg.sv | 17 +
 rtl/sound_rom_arbiter_if.sv | 26 ++
 rtl/sound_rr_pick.sv | 35 +++
 rtl/sound_rom_arbiter.sv | 135 +++++++++++++
 tb/tb_sound_rom_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared constants for the sound ROM arbiter: FSM encoding, default bus widths
// and the WAIT timeout limit.
package sound_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_LOAD = 2'd1;
    localparam arb_state_t ST_WAIT = 2'd2;
    localparam arb_state_t ST_DONE = 2'd3;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;
    localparam int WAIT_W      = 8;

endpackage

// File: rtl/sound_rom_arbiter_if.sv
// ROM fetch handshake between the arbiter (master) and the sound ROM (slave).
interface sound_rom_arbiter_if
    import sound_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              rom_load;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rom_ready;

    modport master (
        output rom_load,
        output rom_addr,
        input  rom_data,
        input  rom_ready
    );

    modport slave (
        input  rom_load,
        input  rom_addr,
        output rom_data,
        output rom_ready
    );
endinterface

// File: rtl/sound_rr_pick.sv
// Combinational rotating-priority pick: first set req bit searching upward
// from last_winner+1, wrapping modulo NUM_REQ.
module sound_rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_winner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sound_rom_arbiter.sv
// Round-robin arbiter sharing one sound ROM fetch port among NUM_REQ channels.
// Define SOUND_ARB_BG_PRIO_EN to give the background channel (0) absolute priority.
module sound_rom_arbiter
    import sound_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      err,
    sound_rom_arbiter_if.master       rom
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  winner_reg;
    logic [IDX_W-1:0]  last_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] rsp_reg;
    logic [WAIT_W-1:0] cnt_reg;
    logic              timeout_reg;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] pick_req;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic              wait_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

`ifdef SOUND_ARB_BG_PRIO_EN
    // Background channel is taken out of the rotation and overrides it.
    assign pick_req  = {req[NUM_REQ-1:1], 1'b0};
    assign sel_valid = req[0] | pick_valid;
    assign sel_idx   = req[0] ? '0 : pick_idx;
`else
    assign pick_req  = req;
    assign sel_valid = pick_valid;
    assign sel_idx   = pick_idx;
`endif

    sound_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (pick_req),
        .last_winner (last_reg),
        .valid       (pick_valid),
        .index       (pick_idx)
    );

    assign wait_expired = (cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (sel_valid) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_WAIT;
            ST_WAIT: if (rom.rom_ready || wait_expired) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            winner_reg  <= '0;
            last_reg    <= IDX_W'(NUM_REQ - 1);
            gnt_reg     <= '0;
            addr_reg    <= '0;
            rsp_reg     <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (sel_valid) begin
                        winner_reg  <= sel_idx;
                        gnt_reg     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        addr_reg    <= addr_arr[sel_idx];
                        timeout_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cnt_reg <= '0;
                end
                ST_WAIT: begin
                    if (rom.rom_ready) begin
                        rsp_reg <= rom.rom_data;
                    end else if (wait_expired) begin
                        rsp_reg     <= '0;
                        timeout_reg <= 1'b1;
                        cnt_reg     <= cnt_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    gnt_reg     <= '0;
                    last_reg    <= winner_reg;
                    cnt_reg     <= '0;
                    timeout_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt          = gnt_reg;
    assign done         = (state_reg == ST_DONE) ? gnt_reg : '0;
    assign err          = (state_reg == ST_DONE) && timeout_reg;
    assign rsp_data     = rsp_reg;
    assign rom.rom_load = (state_reg == ST_LOAD);
    assign rom.rom_addr = addr_reg;

endmodule

// File: tb/tb_sound_rom_arbiter.sv
// Directed bench for sound_rom_arbiter with a completion scoreboard and a
// behavioural ROM whose data is a fixed function of the fetch address.
module tb_sound_rom_arbiter;

    localparam int NR  = 5;
    localparam int AW  = 24;
    localparam int DW  = 8;
    localparam int TO  = 255;

    typedef struct {
        logic [NR-1:0] done;
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [DW-1:0]    rsp_data;
    logic             err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rom_mode = 0;   // 0: never ready, 1: always ready, 2: ready one cycle after LOAD
    logic load_seen = 1'b0;
    logic ready_pulse = 1'b0;
    exp_t sb_q[$];
    logic [AW-1:0] addr_tab [NR];

    sound_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

    sound_rom_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .done     (done),
        .rsp_data (rsp_data),
        .err      (err),
        .rom      (rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA4;
    endfunction

    assign rif.rom_data  = rom_fn(rif.rom_addr);
    assign rif.rom_ready = (rom_mode == 1) || ((rom_mode == 2) && ready_pulse);

    always @(negedge clk) begin
        ready_pulse = load_seen;
        load_seen   = rif.rom_load;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [NR-1:0] d, logic [DW-1:0] dat, logic e, int c);
        exp_t x;
        x.done = d;
        x.data = dat;
        x.err  = e;
        x.cyc  = c;
        sb_q.push_back(x);
    endtask

    task automatic load_addrs();
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_tab[i];
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done !== '0) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed done=%b expected none", done);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("txn cyc=%0d done=%b rsp_data=%h err=%b", cyc, done, rsp_data, err);
                chk("done_vec", 32'(done), 32'(e.done));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("err_flag", 32'(err), 32'(e.err));
                chk("done_cyc", cyc, e.cyc);
            end
        end else if (err !== 1'b0) begin
            checks++;
            assert (err === 1'b0) else begin
                errors++;
                $error("FAIL err_alone: observed err=%b expected 0", err);
            end
        end
    end

    initial begin
        int c0;
        logic [NR-1:0] one;
        int idx;
        one = 5'b00001;
        addr_tab[0] = 24'h000100;
        addr_tab[1] = 24'h00A2B3;
        addr_tab[2] = 24'h013C4D;
        addr_tab[3] = 24'h0255E6;
        addr_tab[4] = 24'h03F071;
        load_addrs();

        // Reset values with the clock running
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_load", 32'(rif.rom_load), 0);
        chk("rst_addr", 32'(rif.rom_addr), 0);
        chk("rst_rsp", 32'(rsp_data), 0);
        rst = 1'b1;

        // Single background fetch, minimum latency
        tick();
        c0 = cyc;
        rom_mode = 2;
        req = 5'b00001;
        push(5'b00001, 8'hA5, 1'b0, c0 + 3);
        chk("t1_idle_load", 32'(rif.rom_load), 0);
        tick();
        req = '0;
        chk("t1_load", 32'(rif.rom_load), 1);
        chk("t1_addr_load", 32'(rif.rom_addr), 32'h000100);
        chk("t1_gnt", 32'(gnt), 32'b00001);
        tick();
        chk("t1_load_off", 32'(rif.rom_load), 0);
        chk("t1_addr_wait", 32'(rif.rom_addr), 32'h000100);
        tick();
        chk("t1_addr_done", 32'(rif.rom_addr), 32'h000100);
        tick();
        chk("t1_gnt_clear", 32'(gnt), 0);
        chk("t1_done_clear", 32'(done), 0);
        repeat (2) tick();
        chk("t1_drain", sb_q.size(), 0);

        // req[3] dropped and its address changed while in WAIT
        c0 = cyc;
        req = 5'b01000;
        push(5'b01000, rom_fn(addr_tab[3]), 1'b0, c0 + 3);
        repeat (2) tick();
        req = '0;
        req_addr[3*AW +: AW] = 24'h7E7E7E;
        repeat (4) tick();
        load_addrs();
        chk("t2_drain", sb_q.size(), 0);

        // Timeout on requester 2, then a normal fetch
        c0 = cyc;
        rom_mode = 0;
        req = 5'b00100;
        push(5'b00100, 8'h00, 1'b1, c0 + 2 + TO);
        tick();
        req = '0;
        repeat (TO + 4) tick();
        chk("t3_drain", sb_q.size(), 0);
        c0 = cyc;
        rom_mode = 2;
        req = 5'b00001;
        push(5'b00001, 8'hA5, 1'b0, c0 + 3);
        tick();
        req = '0;
        repeat (5) tick();
        chk("t3_next_drain", sb_q.size(), 0);

        // Reset asserted during WAIT drops the transaction
        rom_mode = 0;
        req = 5'b10000;
        tick();
        req = '0;
        repeat (2) tick();
        chk("t4_gnt_pre", 32'(gnt), 32'b10000);
        rst = 1'b0;
        #1;
        chk("t4_gnt", 32'(gnt), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_err", 32'(err), 0);
        chk("t4_load", 32'(rif.rom_load), 0);
        chk("t4_addr", 32'(rif.rom_addr), 0);
        chk("t4_rsp", 32'(rsp_data), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        c0 = cyc;
        rom_mode = 2;
        req = 5'b00010;
        push(5'b00010, rom_fn(addr_tab[1]), 1'b0, c0 + 3);
        tick();
        req = '0;
        repeat (5) tick();
        chk("t4_drain", sb_q.size(), 0);

        // All requesters held, ROM always ready (also while IDLE/LOAD/DONE)
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        c0 = cyc;
        rom_mode = 1;
        req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
`ifdef SOUND_ARB_BG_PRIO_EN
            idx = 0;
`else
            idx = k % NR;
`endif
            push(one << idx, rom_fn(addr_tab[idx]), 1'b0, c0 + 3 + 4 * k);
        end
        repeat (23) tick();
        req = '0;
        repeat (6) tick();
        chk("t5_drain", sb_q.size(), 0);
        chk("t5_idle_gnt", 32'(gnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
